mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the AGU load/store path (LS).
- Arbitrates new requests and keeps at most one transaction outstanding.
- Returns each response to the requester that owns the transaction.
- LS has priority; a starvation counter bounds how long IF can wait behind LS.

Parameters:
- STARVE_MAX, 4: consecutive LS grants allowed while IF is pending before IF is forced to win once (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req_val  in  1  IF request valid
- if_req_rdy  out  1  IF request accepted
- if_adr  in  32  IF word address
- if_rsp_val  out  1  IF response valid (one-cycle pulse)
- if_rsp_dat  out  32  IF read data
- ls_req_val  in  1  LS request valid (the AGU's val, already masked for misalignment)
- ls_req_rdy  out  1  LS request accepted
- ls_adr  in  32  LS address
- ls_wdat  in  32  LS lane-aligned write data
- ls_wen  in  4  LS byte write enables
- ls_ren  in  1  LS read enable
- ls_rsp_val  out  1  LS response valid (one-cycle pulse; also acks stores)
- ls_rsp_dat  out  32  LS raw read word
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_adr  out  32  memory address
- mem_wdat  out  32  memory write data
- mem_wen  out  4  memory byte enables
- mem_ren  out  1  memory read enable
- mem_rsp_val  in  1  memory response valid
- mem_rsp_dat  in  32  memory read data

Behaviour:
- Reset:
  - state=IDLE, starve_cnt=0.
  - In IDLE with no requests, every output is 0.
  - Reset mid-transaction abandons ownership; a late mem_rsp_val is ignored.
- States:
  - IDLE: arbitrate.
  - BUSY_IF: IF transaction outstanding.
  - BUSY_LS: LS transaction outstanding.
- Grant rule in IDLE (combinational, zero-cycle request-to-mem latency):
  - sel_if = if_req_val & (~ls_req_val | starve_cnt==STARVE_MAX).
  - sel_ls = ls_req_val & ~sel_if.
- Request muxing:
  - mem_req_val = sel_if | sel_ls.
  - Address and controls come from the selected requester.
  - For IF: mem_ren=1, mem_wen=0, mem_wdat=0.
  - All mem_* request outputs are 0 when nothing is selected.
- Request readies:
  - if_req_rdy = sel_if & mem_req_rdy.
  - ls_req_rdy = sel_ls & mem_req_rdy.
  - Both readies are 0 in BUSY states.
- IDLE transitions:
  - mem_req_val & mem_req_rdy moves to BUSY_IF or BUSY_LS, according to which requester was selected.
  - Otherwise stay in IDLE; unaccepted requests are re-arbitrated next cycle.
- BUSY transitions:
  - Wait for mem_rsp_val.
  - In that cycle, pulse the owner's rsp_val and pass mem_rsp_dat through combinationally.
  - Return to IDLE the next cycle.
  - No new request is issued in the response cycle; back-to-back throughput is 1 transaction per (accept + response + 1) cycles.
- Response outputs:
  - Non-owner rsp_val stays 0.
  - rsp_dat of both requesters is 0 when its rsp_val=0.
- starve_cnt, updated on each accepted request:
  - LS accepted while if_req_val=1: increment, saturating at STARVE_MAX.
  - IF accepted: clear to 0.
  - LS accepted with if_req_val=0: clear to 0.
- Simultaneous requests:
  - LS wins unless starve_cnt==STARVE_MAX.
- Spurious response:
  - mem_rsp_val in IDLE is ignored: no rsp pulse, no state change.
- Requester stability:
  - Requesters hold val and payload stable until rdy. The block does not register payloads; its outputs follow its inputs while a request is pending.

Test Plan:
- Single IF read:
  - Stimulus: if_req_val=1, if_adr=0x100, mem_req_rdy=1, mem_rsp_val two cycles later with dat=0xDEADBEEF.
  - Required: mem_adr=0x100, mem_ren=1 in the request cycle; if_rsp_val pulses 1 cycle with 0xDEADBEEF; ls_rsp_val=0.
- LS store:
  - Stimulus: ls_adr=0x203, ls_wen=4'b1000, ls_wdat=0xAB000000.
  - Required: mem_wen=4'b1000, mem_ren=0, mem_wdat=0xAB000000; ls_rsp_val pulses on mem_rsp_val.
- Simultaneous requests:
  - Stimulus: IF and LS request in the same cycle with starve_cnt=0.
  - Required: LS granted, if_req_rdy=0; IF granted on the next IDLE cycle.
- Starvation:
  - Stimulus: IF held valid while LS issues 6 back-to-back requests, STARVE_MAX=4.
  - Required: grant order LS,LS,LS,LS,IF,LS; starve_cnt returns to 0 after the IF grant.
- Backpressure and spurious response:
  - Stimulus: mem_req_rdy=0 for 3 cycles; also drive mem_rsp_val while in IDLE.
  - Required: stays in IDLE, both rdy=0, mem_req_val held; no rsp pulse from the IDLE response.
- Reset mid-transaction:
  - Stimulus: rst asserted in BUSY_LS, then mem_rsp_val arrives after release.
  - Required: all outputs 0 during reset; state IDLE after release; no ls_rsp_val pulse.

Source files
------------

// File: rtl/mem_port_arb.sv
// Arbiter sharing one memory port between instruction fetch and load/store.
// LS has priority; a starvation counter forces one IF grant after STARVE_MAX LS wins.
module mem_port_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_val,
  output logic        if_req_rdy,
  input  logic [31:0] if_adr,
  output logic        if_rsp_val,
  output logic [31:0] if_rsp_dat,
  input  logic        ls_req_val,
  output logic        ls_req_rdy,
  input  logic [31:0] ls_adr,
  input  logic [31:0] ls_wdat,
  input  logic [3:0]  ls_wen,
  input  logic        ls_ren,
  output logic        ls_rsp_val,
  output logic [31:0] ls_rsp_dat,
  output logic        mem_req_val,
  input  logic        mem_req_rdy,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdat,
  output logic [3:0]  mem_wen,
  output logic        mem_ren,
  input  logic        mem_rsp_val,
  input  logic [31:0] mem_rsp_dat
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             starved;
  logic             sel_if, sel_ls;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // State and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Arbitration, request mux, response routing and next state
  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    sel_if      = 1'b0;
    sel_ls      = 1'b0;
    if_req_rdy  = 1'b0;
    ls_req_rdy  = 1'b0;
    if_rsp_val  = 1'b0;
    if_rsp_dat  = '0;
    ls_rsp_val  = 1'b0;
    ls_rsp_dat  = '0;
    mem_req_val = 1'b0;
    mem_adr     = '0;
    mem_wdat    = '0;
    mem_wen     = '0;
    mem_ren     = 1'b0;

    case (state)
      IDLE: begin
        // No grant while reset is held so every output stays quiet
        if (!rst) begin
          sel_if = if_req_val & (~ls_req_val | starved);
          sel_ls = ls_req_val & ~sel_if;
        end
        mem_req_val = sel_if | sel_ls;
        if (sel_if) begin
          mem_adr = if_adr;
          mem_ren = 1'b1;
        end else if (sel_ls) begin
          mem_adr  = ls_adr;
          mem_wdat = ls_wdat;
          mem_wen  = ls_wen;
          mem_ren  = ls_ren;
        end
        if_req_rdy = sel_if & mem_req_rdy;
        ls_req_rdy = sel_ls & mem_req_rdy;

        if (mem_req_val && mem_req_rdy) begin
          if (sel_if) begin
            state_nxt  = BUSY_IF;
            starve_nxt = '0;
          end else begin
            state_nxt = BUSY_LS;
            if (if_req_val) begin
              starve_nxt = starved ? starve_cnt : starve_cnt + CNT_W'(1);
            end else begin
              starve_nxt = '0;
            end
          end
        end
      end

      BUSY_IF: begin
        if (mem_rsp_val) begin
          if_rsp_val = 1'b1;
          if_rsp_dat = mem_rsp_dat;
          state_nxt  = IDLE;
        end
      end

      BUSY_LS: begin
        if (mem_rsp_val) begin
          ls_rsp_val = 1'b1;
          ls_rsp_dat = mem_rsp_dat;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arb;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_val, if_req_rdy, if_rsp_val;
  logic [31:0] if_adr, if_rsp_dat;
  logic        ls_req_val, ls_req_rdy, ls_ren, ls_rsp_val;
  logic [31:0] ls_adr, ls_wdat, ls_rsp_dat;
  logic [3:0]  ls_wen;
  logic        mem_req_val, mem_req_rdy, mem_ren, mem_rsp_val;
  logic [31:0] mem_adr, mem_wdat, mem_rsp_dat;
  logic [3:0]  mem_wen;

  mem_port_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req_val(if_req_val), .if_req_rdy(if_req_rdy), .if_adr(if_adr),
    .if_rsp_val(if_rsp_val), .if_rsp_dat(if_rsp_dat),
    .ls_req_val(ls_req_val), .ls_req_rdy(ls_req_rdy), .ls_adr(ls_adr),
    .ls_wdat(ls_wdat), .ls_wen(ls_wen), .ls_ren(ls_ren),
    .ls_rsp_val(ls_rsp_val), .ls_rsp_dat(ls_rsp_dat),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_adr(mem_adr),
    .mem_wdat(mem_wdat), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_dat(mem_rsp_dat)
  );

  always #5 clk = ~clk;

  int  n_tot = 0;
  int  n_bad = 0;
  // Reference model: who owns the port (0 none, 1 IF, 2 LS) and LS wins while IF waits
  int  m_owner = 0;
  int  m_starve = 0;
  bit  m_acc_if, m_acc_ls;
  bit  log_en = 1'b0;
  byte glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check all outputs against the model for the current cycle, then advance one clock
  task automatic step();
    bit          w_if, w_ls, e_irsp, e_lrsp;
    logic [31:0] e_adr, e_wdat;
    logic [3:0]  e_wen;
    logic        e_ren;
    #2;
    if (rst) begin
      m_owner  = 0;
      m_starve = 0;
    end
    w_if = 1'b0; w_ls = 1'b0;
    e_adr = '0; e_wdat = '0; e_wen = '0; e_ren = 1'b0;
    if (!rst && m_owner == 0) begin
      w_if = if_req_val && (!ls_req_val || m_starve == SM);
      w_ls = ls_req_val && !w_if;
    end
    if (w_if) begin
      e_adr = if_adr;
      e_ren = 1'b1;
    end else if (w_ls) begin
      e_adr = ls_adr; e_wdat = ls_wdat; e_wen = ls_wen; e_ren = ls_ren;
    end
    e_irsp = (m_owner == 1) && mem_rsp_val;
    e_lrsp = (m_owner == 2) && mem_rsp_val;
    check("mem_req_val", 32'(mem_req_val), 32'(w_if | w_ls));
    check("mem_adr",     mem_adr, e_adr);
    check("mem_wdat",    mem_wdat, e_wdat);
    check("mem_wen",     32'(mem_wen), 32'(e_wen));
    check("mem_ren",     32'(mem_ren), 32'(e_ren));
    check("if_req_rdy",  32'(if_req_rdy), 32'(w_if && mem_req_rdy));
    check("ls_req_rdy",  32'(ls_req_rdy), 32'(w_ls && mem_req_rdy));
    check("if_rsp_val",  32'(if_rsp_val), 32'(e_irsp));
    check("if_rsp_dat",  if_rsp_dat, e_irsp ? mem_rsp_dat : 32'h0);
    check("ls_rsp_val",  32'(ls_rsp_val), 32'(e_lrsp));
    check("ls_rsp_dat",  ls_rsp_dat, e_lrsp ? mem_rsp_dat : 32'h0);
    m_acc_if = w_if && mem_req_rdy;
    m_acc_ls = w_ls && mem_req_rdy;
    if (log_en && if_req_rdy) glog.push_back(8'h49);
    if (log_en && ls_req_rdy) glog.push_back(8'h4C);
    @(posedge clk);
    if (rst) begin
      m_owner  = 0;
      m_starve = 0;
    end else if (m_owner != 0) begin
      if (mem_rsp_val) m_owner = 0;
    end else if (m_acc_if) begin
      m_owner  = 1;
      m_starve = 0;
    end else if (m_acc_ls) begin
      m_owner  = 2;
      m_starve = if_req_val ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
    end
    #1;
  endtask

  task automatic clr_in();
    if_req_val = 1'b0; if_adr = '0;
    ls_req_val = 1'b0; ls_adr = '0; ls_wdat = '0; ls_wen = '0; ls_ren = 1'b0;
    mem_req_rdy = 1'b0; mem_rsp_val = 1'b0; mem_rsp_dat = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  byte exp_ord [6];

  initial begin
    clr_in();
    do_reset();

    // Single IF read
    if_req_val = 1'b1; if_adr = 32'h100; mem_req_rdy = 1'b1;
    #1;
    check("if_rd_adr", mem_adr, 32'h100);
    check("if_rd_ren", 32'(mem_ren), 32'd1);
    step();
    if_req_val = 1'b0;
    step();
    mem_rsp_val = 1'b1; mem_rsp_dat = 32'hDEADBEEF;
    #1;
    check("if_rd_rsp", 32'(if_rsp_val), 32'd1);
    check("if_rd_dat", if_rsp_dat, 32'hDEADBEEF);
    check("if_rd_lsrsp", 32'(ls_rsp_val), 32'd0);
    step();
    mem_rsp_val = 1'b0; mem_rsp_dat = '0;
    step();

    // LS store
    ls_req_val = 1'b1; ls_adr = 32'h203; ls_wen = 4'b1000; ls_wdat = 32'hAB000000;
    #1;
    check("st_wen",  32'(mem_wen), 32'h8);
    check("st_ren",  32'(mem_ren), 32'd0);
    check("st_wdat", mem_wdat, 32'hAB000000);
    step();
    clr_in(); mem_req_rdy = 1'b1; mem_rsp_val = 1'b1;
    #1;
    check("st_ack", 32'(ls_rsp_val), 32'd1);
    step();
    mem_rsp_val = 1'b0;

    // Simultaneous requests with an empty starvation count
    if_req_val = 1'b1; if_adr = 32'h400;
    ls_req_val = 1'b1; ls_adr = 32'h500; ls_ren = 1'b1;
    #1;
    check("sim_ls_rdy", 32'(ls_req_rdy), 32'd1);
    check("sim_if_rdy", 32'(if_req_rdy), 32'd0);
    step();
    ls_req_val = 1'b0; mem_rsp_val = 1'b1;
    step();
    mem_rsp_val = 1'b0;
    #1;
    check("sim_if_next", 32'(if_req_rdy), 32'd1);
    step();
    if_req_val = 1'b0; mem_rsp_val = 1'b1;
    step();
    clr_in();

    // Starvation: IF held while LS streams requests
    do_reset();
    if_req_val = 1'b1; if_adr = 32'h300;
    ls_req_val = 1'b1; ls_adr = 32'h600; ls_ren = 1'b1;
    mem_req_rdy = 1'b1; mem_rsp_val = 1'b1; mem_rsp_dat = 32'h12345678;
    log_en = 1'b1;
    for (int i = 0; i < 14; i++) step();
    log_en = 1'b0;
    exp_ord = '{8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h49, 8'h4C};
    check("starve_cnt_grants", 32'(glog.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) check($sformatf("starve_ord%0d", i), 32'(glog[i]), 32'(exp_ord[i]));
    end
    clr_in();
    step();

    // Backpressure with a spurious response while idle
    if_req_val = 1'b1; if_adr = 32'h700; mem_rsp_val = 1'b1; mem_rsp_dat = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_val",  32'(mem_req_val), 32'd1);
      check("bp_rdy",  32'({if_req_rdy, ls_req_rdy}), 32'd0);
      check("bp_spur", 32'({if_rsp_val, ls_rsp_val}), 32'd0);
      step();
    end
    mem_rsp_val = 1'b0; mem_req_rdy = 1'b1;
    step();
    if_req_val = 1'b0; mem_rsp_val = 1'b1;
    step();
    clr_in();

    // Reset while an LS transaction is outstanding
    ls_req_val = 1'b1; ls_adr = 32'h800; ls_ren = 1'b1; mem_req_rdy = 1'b1;
    step();
    ls_adr = 32'h804; rst = 1'b1;
    #1;
    check("rst_mem_val", 32'(mem_req_val), 32'd0);
    check("rst_ls_rdy",  32'(ls_req_rdy), 32'd0);
    step();
    rst = 1'b0; ls_req_val = 1'b0; mem_rsp_val = 1'b1; mem_rsp_dat = 32'hCAFEF00D;
    #1;
    check("rst_late_rsp", 32'(ls_rsp_val), 32'd0);
    step();
    clr_in();
    step();

    // Random traffic with requester stability honoured
    m_acc_if = 1'b0; m_acc_ls = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!if_req_val || m_acc_if) begin
        if_req_val = ($urandom_range(0, 2) != 0);
        if_adr     = $urandom;
      end
      if (!ls_req_val || m_acc_ls) begin
        ls_req_val = ($urandom_range(0, 2) != 0);
        ls_adr     = $urandom;
        ls_wdat    = $urandom;
        ls_wen     = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        ls_ren     = (ls_wen == 4'h0);
      end
      mem_req_rdy = ($urandom_range(0, 3) != 0);
      mem_rsp_val = ($urandom_range(0, 2) == 0);
      mem_rsp_dat = $urandom;
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
